// File: rtl/spi_subnode_pkg.sv
// Shared types and width helpers for the serial subnode controller.
package spi_subnode_pkg;

  // Frame sequencing states of the subnode controller.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_MSG,
    ST_KEY,
    ST_START,
    ST_WAIT,
    ST_SHIFT,
    ST_HOLD
  } state_e;

  // Key-mode header encodings.
  typedef enum logic [1:0] {
    KM_128 = 2'b00,
    KM_192 = 2'b01,
    KM_256 = 2'b10,
    KM_BAD = 2'b11
  } key_mode_e;

  // Message block width in bits for a block of nb 32-bit words.
  function automatic int msg_width(input int nb);
    return 32 * nb;
  endfunction

  // Key register width in bits for at most max_nk 32-bit words.
  function automatic int key_width(input int max_nk);
    return 32 * max_nk;
  endfunction

  // Bit counter width: must be able to hold a full key length.
  function automatic int cnt_width(input int max_nk);
    return $clog2(32 * max_nk + 1);
  endfunction

  // Key length in bits selected by a header mode; 0 marks the illegal code.
  function automatic int key_bits(input logic [1:0] mode);
    case (mode)
      KM_128:  return 128;
      KM_192:  return 192;
      KM_256:  return 256;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/spi_subnode_ctrl_if.sv
// Serial link and core-side bundle of the subnode controller.
// master = link master plus encryption core, slave = the subnode itself.
interface spi_subnode_ctrl_if #(
  parameter int NB     = 4,
  parameter int MAX_NK = 8
);
  import spi_subnode_pkg::*;

  localparam int MSG_W = msg_width(NB);
  localparam int KEY_W = key_width(MAX_NK);

  // Serial link
  logic             cs;
  logic             sdi;
  logic             sdo;
  logic             sdo_oe;
  // Core side
  logic [MSG_W-1:0] to_enc_dec_msg;
  logic [KEY_W-1:0] to_enc_dec_key;
  logic [1:0]       key_mode;
  logic             enc_start;
  logic             enc_done;
  logic [MSG_W-1:0] from_enc_dec_msg;

  modport master (
    output cs, sdi, enc_done, from_enc_dec_msg,
    input  sdo, sdo_oe, to_enc_dec_msg, to_enc_dec_key, key_mode, enc_start
  );

  modport slave (
    input  cs, sdi, enc_done, from_enc_dec_msg,
    output sdo, sdo_oe, to_enc_dec_msg, to_enc_dec_key, key_mode, enc_start
  );

endinterface

// File: rtl/spi_piso_shift.sv
// Parallel-load, MSB-first shift register feeding the serial output.
module spi_piso_shift #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  // Load has priority over shift; zeros enter from the LSB side.
  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= {sr[W-2:0], 1'b0};
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/spi_subnode_ctrl.sv
// Serial subnode: deserialises header/message/key within one cs frame,
// hands them to the crypto core, then serialises the core result on sdo.
// Assumes HDR_W >= 2 (the key mode is taken from the last two header bits).
module spi_subnode_ctrl
  import spi_subnode_pkg::*;
#(
  parameter int NB     = 4,
  parameter int MAX_NK = 8,
  parameter int HDR_W  = 2
) (
  input  logic                in_clk,
  input  logic                rst,
  spi_subnode_ctrl_if.slave   bus,
  output logic                busy,
  output logic                frame_err
);

  localparam int MSG_W = msg_width(NB);
  localparam int KEY_W = key_width(MAX_NK);
  localparam int CNT_W = cnt_width(MAX_NK);

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 2);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [MSG_W-1:0] msg_q;
  logic [KEY_W-1:0] key_q;
  logic [1:0]       mode_q;
  logic [1:0]       mode_hdr;
  logic             mode_ok;
  logic [CNT_W-1:0] key_last;
  logic             hdr_shift, msg_shift, key_shift, key_clr;
  logic             set_err, clr_err;
  logic             piso_load, piso_shift, piso_msb;

  // Mode value as it will stand after the header bit currently on sdi.
  assign mode_hdr = {mode_q[0], bus.sdi};
  assign mode_ok  = (mode_hdr != KM_BAD) && (key_bits(mode_hdr) <= KEY_W);
  assign key_last = CNT_W'(key_bits(mode_q) - 1);

  // State and bit counter registers; the counter restarts on every state change.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode plus the enables for the datapath registers.
  // NOTE: every signal gets a default first so no branch can infer a latch.
  always_comb begin
    state_nxt  = state;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    hdr_shift  = 1'b0;
    msg_shift  = 1'b0;
    key_shift  = 1'b0;
    key_clr    = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!bus.cs) begin
          hdr_shift = 1'b1;
          clr_err   = 1'b1;
          state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (bus.cs) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          hdr_shift = 1'b1;
          if (cnt == HDR_LAST) begin
            if (mode_ok) begin
              state_nxt = ST_MSG;
            end else begin
              set_err   = 1'b1;
              state_nxt = ST_HOLD;
            end
          end
        end
      end
      ST_MSG: begin
        if (bus.cs) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          msg_shift = 1'b1;
          if (cnt == MSG_LAST) begin
            key_clr   = 1'b1;
            state_nxt = ST_KEY;
          end
        end
      end
      ST_KEY: begin
        if (bus.cs) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          key_shift = 1'b1;
          if (cnt == key_last) state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bus.cs) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.cs) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (bus.enc_done) begin
          piso_load = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.cs) begin
          set_err   = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          piso_shift = 1'b1;
          if (cnt == MSG_LAST) state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.cs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    cnt_nxt = cnt;
    if (state_nxt != state)  cnt_nxt = '0;
    else if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
  end

  // Deserialising shifts and the sticky error flag.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      mode_q    <= '0;
      msg_q     <= '0;
      key_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      if (clr_err)      frame_err <= 1'b0;
      else if (set_err) frame_err <= 1'b1;

      if (hdr_shift) mode_q <= mode_hdr;
      if (msg_shift) msg_q  <= {msg_q[MSG_W-2:0], bus.sdi};

      // Clearing on entry keeps the unused upper key bits at zero.
      if (key_clr)        key_q <= '0;
      else if (key_shift) key_q <= {key_q[KEY_W-2:0], bus.sdi};
    end
  end

  spi_piso_shift #(
    .W (MSG_W)
  ) u_piso (
    .clk   (in_clk),
    .rst   (rst),
    .load  (piso_load),
    .shift (piso_shift),
    .din   (bus.from_enc_dec_msg),
    .msb   (piso_msb)
  );

  // Status and handshake outputs decode straight from the state register.
  assign busy           = (state != ST_IDLE);
  assign bus.enc_start  = (state == ST_START);
  assign bus.sdo_oe     = (state == ST_SHIFT);
  assign bus.sdo        = bus.sdo_oe & piso_msb;
  assign bus.key_mode   = mode_q;
  assign bus.to_enc_dec_msg = msg_q;
  assign bus.to_enc_dec_key = key_q;

endmodule

// File: tb/tb_spi_subnode_ctrl.sv
// Self-checking bench for spi_subnode_ctrl: directed and randomized frames
// against a bit-stream reference model of the subnode and a simple core model.
module tb_spi_subnode_ctrl;

  localparam int NB     = 4;
  localparam int MAX_NK = 8;
  localparam int HDR_W  = 2;
  localparam int MSG_W  = 32 * NB;
  localparam int KEY_W  = 32 * MAX_NK;

  logic in_clk;
  logic rst;
  logic busy;
  logic frame_err;

  int checks = 0;
  int errors = 0;

  spi_subnode_ctrl_if #(.NB(NB), .MAX_NK(MAX_NK)) bus ();

  spi_subnode_ctrl #(
    .NB     (NB),
    .MAX_NK (MAX_NK),
    .HDR_W  (HDR_W)
  ) dut (
    .in_clk    (in_clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .frame_err (frame_err)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Key length in bits for a legal header mode: 128 + 64 per step.
  function automatic int mode_bits(input logic [1:0] m);
    return 128 + 64 * int'(m);
  endfunction

  function automatic logic [KEY_W-1:0] rand_vec();
    logic [KEY_W-1:0] v;
    for (int i = 0; i < KEY_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One legal frame: header, message, key; the core answers msg ^ key after
  // done_delay cycles and holds enc_done for done_len cycles. rst_at >= 0
  // pulses rst after that many result bits have been observed.
  task automatic do_frame(input string tag, input logic [1:0] mode,
                          input logic [MSG_W-1:0] msg, input logic [KEY_W-1:0] key,
                          input int done_delay, input int done_len, input int rst_at);
    int kb, total, early, oe_cycles;
    logic b;
    logic [KEY_W-1:0] key_exp, junk;
    logic [MSG_W-1:0] res, got;

    kb      = mode_bits(mode);
    total   = HDR_W + MSG_W + kb;
    key_exp = '0;
    for (int j = 0; j < kb; j++) key_exp[j] = key[j];
    res   = msg ^ key_exp[MSG_W-1:0];
    early = 0;

    for (int j = 0; j < total; j++) begin
      @(negedge in_clk);
      if (bus.enc_start === 1'b1) early++;
      if (j == 1) begin
        check({tag, "_busy_first"}, KEY_W'(busy), KEY_W'(1));
        check({tag, "_err_clr"}, KEY_W'(frame_err), KEY_W'(0));
      end
      if (j < HDR_W)              b = mode[HDR_W-1-j];
      else if (j < HDR_W + MSG_W) b = msg[MSG_W-1-(j-HDR_W)];
      else                        b = key[kb-1-(j-HDR_W-MSG_W)];
      bus.cs  = 1'b0;
      bus.sdi = b;
    end

    @(negedge in_clk);
    bus.sdi = 1'($urandom);
    check({tag, "_no_early_start"}, KEY_W'(early), KEY_W'(0));
    check({tag, "_start"}, KEY_W'(bus.enc_start), KEY_W'(1));
    check({tag, "_mode"}, KEY_W'(bus.key_mode), KEY_W'(mode));
    check({tag, "_msg"}, KEY_W'(bus.to_enc_dec_msg), KEY_W'(msg));
    check({tag, "_key"}, bus.to_enc_dec_key, key_exp);

    for (int i = 1; i <= done_delay; i++) begin
      @(negedge in_clk);
      if (i == 1) check({tag, "_start_1cyc"}, KEY_W'(bus.enc_start), KEY_W'(0));
      if (i == done_delay) begin
        check({tag, "_oe_wait"}, KEY_W'(bus.sdo_oe), KEY_W'(0));
        bus.enc_done         = 1'b1;
        bus.from_enc_dec_msg = res;
      end
      bus.sdi = 1'($urandom);
    end

    oe_cycles = 0;
    got       = '0;
    for (int i = 1; i <= MSG_W + 2; i++) begin
      @(negedge in_clk);
      if (i == 1) check({tag, "_oe_first"}, KEY_W'(bus.sdo_oe), KEY_W'(1));
      if (i == MSG_W + 1) check({tag, "_oe_off"}, KEY_W'(bus.sdo_oe), KEY_W'(0));
      if (bus.sdo_oe === 1'b1) begin
        if (oe_cycles < MSG_W) got[MSG_W-1-oe_cycles] = bus.sdo;
        oe_cycles++;
      end
      if (i == done_len) begin
        junk                 = rand_vec();
        bus.enc_done         = 1'b0;
        bus.from_enc_dec_msg = junk[MSG_W-1:0];
      end
      if (rst_at >= 0 && oe_cycles == rst_at) begin
        check({tag, "_prefix"}, KEY_W'(got >> (MSG_W - rst_at)), KEY_W'(res >> (MSG_W - rst_at)));
        #2 rst = 1'b1;
        #1;
        check({tag, "_rst_oe"}, KEY_W'(bus.sdo_oe), KEY_W'(0));
        check({tag, "_rst_sdo"}, KEY_W'(bus.sdo), KEY_W'(0));
        check({tag, "_rst_busy"}, KEY_W'(busy), KEY_W'(0));
        check({tag, "_rst_msg"}, KEY_W'(bus.to_enc_dec_msg), KEY_W'(0));
        check({tag, "_rst_key"}, bus.to_enc_dec_key, KEY_W'(0));
        check({tag, "_rst_mode"}, KEY_W'(bus.key_mode), KEY_W'(0));
        @(negedge in_clk);
        bus.cs       = 1'b1;
        bus.enc_done = 1'b0;
        rst          = 1'b0;
        return;
      end
      bus.sdi = 1'($urandom);
    end

    check({tag, "_oe_cycles"}, KEY_W'(oe_cycles), KEY_W'(MSG_W));
    check({tag, "_result"}, KEY_W'(got), KEY_W'(res));
    check({tag, "_busy_hold"}, KEY_W'(busy), KEY_W'(1));
    bus.cs = 1'b1;
    @(negedge in_clk);
    check({tag, "_busy_off"}, KEY_W'(busy), KEY_W'(0));
    check({tag, "_err"}, KEY_W'(frame_err), KEY_W'(0));
    check({tag, "_msg_kept"}, KEY_W'(bus.to_enc_dec_msg), KEY_W'(msg));
    check({tag, "_key_kept"}, bus.to_enc_dec_key, key_exp);
  endtask

  initial begin
    logic [KEY_W-1:0] r1, r2;
    int n_start, n_oe;
    logic [1:0] m;

    rst                  = 1'b1;
    bus.cs               = 1'b1;
    bus.sdi              = 1'b0;
    bus.enc_done         = 1'b0;
    bus.from_enc_dec_msg = '0;
    #12;
    check("rst_busy", KEY_W'(busy), KEY_W'(0));
    check("rst_err", KEY_W'(frame_err), KEY_W'(0));
    check("rst_sdo", KEY_W'(bus.sdo), KEY_W'(0));
    check("rst_oe", KEY_W'(bus.sdo_oe), KEY_W'(0));
    check("rst_start", KEY_W'(bus.enc_start), KEY_W'(0));
    check("rst_msg", KEY_W'(bus.to_enc_dec_msg), KEY_W'(0));
    check("rst_key", bus.to_enc_dec_key, KEY_W'(0));
    check("rst_mode", KEY_W'(bus.key_mode), KEY_W'(0));
    @(negedge in_clk);
    rst = 1'b0;
    @(negedge in_clk);

    // 256-bit key of all ones
    r1 = rand_vec();
    do_frame("m256_ones", 2'b10, r1[MSG_W-1:0], '1, 2, 1, -1);

    // Directed 128-bit frame; upper key bits must be cleared after the all-ones key
    do_frame("m128_dir", 2'b00, 128'h00112233_44556677_8899AABB_CCDDEEFF,
             {128'h0, 128'h00010203_04050607_08090A0B_0C0D0E0F}, 3, 1, -1);

    // Illegal mode 11: error, no start, no output, core done ignored
    @(negedge in_clk);
    bus.cs  = 1'b0;
    bus.sdi = 1'b1;
    @(negedge in_clk);
    bus.sdi = 1'b1;
    @(negedge in_clk);
    check("bad_err", KEY_W'(frame_err), KEY_W'(1));
    check("bad_busy", KEY_W'(busy), KEY_W'(1));
    n_start = 0;
    n_oe    = 0;
    for (int i = 0; i < 20; i++) begin
      bus.sdi      = 1'($urandom);
      bus.enc_done = (i == 5);
      @(negedge in_clk);
      if (bus.enc_start === 1'b1) n_start++;
      if (bus.sdo_oe === 1'b1) n_oe++;
    end
    bus.enc_done = 1'b0;
    check("bad_no_start", KEY_W'(n_start), KEY_W'(0));
    check("bad_no_oe", KEY_W'(n_oe), KEY_W'(0));
    bus.cs = 1'b1;
    @(negedge in_clk);
    check("bad_busy_off", KEY_W'(busy), KEY_W'(0));
    check("bad_err_sticky", KEY_W'(frame_err), KEY_W'(1));

    // Legal 192-bit frame clears the error on its first bit
    r1 = rand_vec();
    r2 = rand_vec();
    do_frame("m192_rand", 2'b01, r1[MSG_W-1:0], r2, 4, 2, -1);

    // Abort after 70 message bits
    for (int j = 0; j < HDR_W + 70; j++) begin
      @(negedge in_clk);
      bus.cs  = 1'b0;
      bus.sdi = (j < HDR_W) ? 1'b0 : 1'($urandom);
    end
    @(negedge in_clk);
    bus.cs = 1'b1;
    @(negedge in_clk);
    check("abort_err", KEY_W'(frame_err), KEY_W'(1));
    check("abort_busy", KEY_W'(busy), KEY_W'(0));
    n_start = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge in_clk);
      if (bus.enc_start === 1'b1) n_start++;
    end
    check("abort_no_start", KEY_W'(n_start), KEY_W'(0));
    r1 = rand_vec();
    r2 = rand_vec();
    do_frame("after_abort", 2'b00, r1[MSG_W-1:0], r2, 3, 1, -1);

    // enc_done held high for 10 cycles
    r1 = rand_vec();
    r2 = rand_vec();
    do_frame("done_hold", 2'b10, r1[MSG_W-1:0], r2, 1, 10, -1);

    // Randomized legal frames
    for (int k = 0; k < 3; k++) begin
      r1 = rand_vec();
      r2 = rand_vec();
      m  = 2'($urandom_range(0, 2));
      do_frame("rand", m, r1[MSG_W-1:0], r2, int'($urandom_range(1, 6)),
               int'($urandom_range(1, 4)), -1);
    end

    // Reset during SHIFT at result bit 40, then a normal frame
    r1 = rand_vec();
    r2 = rand_vec();
    do_frame("rst_shift", 2'b00, r1[MSG_W-1:0], r2, 3, 1, 40);
    @(negedge in_clk);
    r1 = rand_vec();
    r2 = rand_vec();
    do_frame("after_rst", 2'b01, r1[MSG_W-1:0], r2, 2, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
